bf_boot_sequencer: RTL and testbench



---
 rtl/bf_boot_sequencer_pkg.sv | 17 +
 rtl/bf_boot_sequencer_if.sv | 32 +++
 rtl/bf_boot_sequencer_counter.sv | 26 ++
 rtl/bf_boot_sequencer.sv | 119 +++++++++++
 tb/tb_bf_boot_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_boot_sequencer_pkg.sv
// bf_boot_sequencer shared types: boot FSM states and the default
// program terminator byte.
package bf_boot_sequencer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    BOOT_CLEAR = 3'd0,
    BOOT_LOAD  = 3'd1,
    BOOT_ACKW  = 3'd2,
    BOOT_RUN   = 3'd3,
    BOOT_ERROR = 3'd4
  } boot_state_t;

  localparam byte_t BOOT_TERM = 8'h00;

endpackage

// File: rtl/bf_boot_sequencer_if.sv
// Host byte link plus the IROM/DRAM write ports owned by the boot
// sequencer while the core is held in reset.
interface bf_boot_sequencer_if
  import bf_boot_sequencer_pkg::*;
#(
  parameter int IA_WIDTH = 12,
  parameter int ID_WIDTH = 8,
  parameter int DA_WIDTH = 12,
  parameter int DD_WIDTH = 8
);
  byte_t               rxd;
  logic                rxrda;
  logic                rxack;
  logic                iwce;
  logic [IA_WIDTH-1:0] iwa;
  logic [ID_WIDTH-1:0] iwd;
  logic                dwce;
  logic [DA_WIDTH-1:0] dwa;
  logic [DD_WIDTH-1:0] dwq;

  modport master (
    input  rxd, rxrda,
    output rxack, iwce, iwa, iwd,
    output dwce, dwa, dwq
  );

  modport slave (
    output rxd, rxrda,
    input  rxack, iwce, iwa, iwd,
    input  dwce, dwa, dwq
  );
endinterface

// File: rtl/bf_boot_sequencer_counter.sv
// Loadable up-counter used for the DRAM and IROM write addresses;
// load wins over count enable.
module bf_boot_sequencer_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_en) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/bf_boot_sequencer.sv
// Boot controller: zero-fills DRAM, loads a program byte stream into
// IROM, then releases the core from reset.
module bf_boot_sequencer
  import bf_boot_sequencer_pkg::*;
#(
  parameter int    IA_WIDTH   = 12,
  parameter int    ID_WIDTH   = 8,
  parameter int    DA_WIDTH   = 12,
  parameter int    DD_WIDTH   = 8,
  parameter byte_t TERMINATOR = BOOT_TERM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  bf_boot_sequencer_if.master bus,
  output logic                core_reset,
  output logic                loaded,
  output logic                error
);
  boot_state_t         r_state;
  boot_state_t         w_next;
  logic                r_rxack;
  logic                r_iwce;
  logic                r_dwce;
  logic                r_core_reset;
  logic                r_loaded;
  logic                r_error;
  byte_t               r_iwd;
  logic [IA_WIDTH-1:0] w_iwa;
  logic [DA_WIDTH-1:0] w_dwa;
  logic                w_take;
  logic                w_iwa_en;
  logic                w_is_term;
  logic                w_iwa_last;
  logic                w_dwa_last;

  assign w_is_term  = (r_iwd == TERMINATOR);
  assign w_iwa_last = (w_iwa == '1);
  assign w_dwa_last = (w_dwa == '1);

  // restart beats a byte arriving on the same cycle
  assign w_take = (r_state == BOOT_LOAD) && bus.rxrda && !restart;

  assign w_iwa_en = (r_state == BOOT_ACKW) && !w_is_term
                    && !w_iwa_last;

  bf_boot_sequencer_counter #(.WIDTH(DA_WIDTH)) u_dwa (
    .clk    (clk),
    .reset  (reset),
    .i_load (restart),
    .i_d    ('0),
    .i_en   (r_dwce),
    .o_q    (w_dwa)
  );

  bf_boot_sequencer_counter #(.WIDTH(IA_WIDTH)) u_iwa (
    .clk    (clk),
    .reset  (reset),
    .i_load (restart),
    .i_d    ('0),
    .i_en   (w_iwa_en),
    .o_q    (w_iwa)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      BOOT_CLEAR: begin
        if (r_dwce && w_dwa_last) w_next = BOOT_LOAD;
      end
      BOOT_LOAD: begin
        if (bus.rxrda) w_next = BOOT_ACKW;
      end
      BOOT_ACKW: begin
        if (w_is_term)       w_next = BOOT_RUN;
        else if (w_iwa_last) w_next = BOOT_ERROR;
        else                 w_next = BOOT_LOAD;
      end
      BOOT_RUN:   w_next = BOOT_RUN;
      BOOT_ERROR: w_next = BOOT_ERROR;
      default:    w_next = BOOT_CLEAR;
    endcase
    if (restart) w_next = BOOT_CLEAR;
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BOOT_CLEAR;
      r_rxack      <= 1'b0;
      r_iwce       <= 1'b0;
      r_iwd        <= '0;
      r_dwce       <= 1'b0;
      r_core_reset <= 1'b1;
      r_loaded     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rxack      <= w_take;
      r_iwce       <= w_take;
      if (w_take) r_iwd <= bus.rxd;
      r_dwce       <= (w_next == BOOT_CLEAR);
      r_core_reset <= (w_next != BOOT_RUN);
      r_loaded     <= (w_next == BOOT_RUN);
      r_error      <= (w_next == BOOT_ERROR);
    end
  end

  assign bus.rxack  = r_rxack;
  assign bus.iwce   = r_iwce;
  assign bus.iwa    = w_iwa;
  assign bus.iwd    = ID_WIDTH'(r_iwd);
  assign bus.dwce   = r_dwce;
  assign bus.dwa    = w_dwa;
  assign bus.dwq    = DD_WIDTH'(0);
  assign core_reset = r_core_reset;
  assign loaded     = r_loaded;
  assign error      = r_error;
endmodule

// File: tb/tb_bf_boot_sequencer.sv
// Bench for bf_boot_sequencer with 16-entry IROM and DRAM; random
// programs are checked against a byte-stream model of the boot rules.
module tb_bf_boot_sequencer;
  import bf_boot_sequencer_pkg::*;

  localparam int    IAW    = 4;
  localparam int    DAW    = 4;
  localparam int    IDEPTH = 1 << IAW;
  localparam int    DDEPTH = 1 << DAW;
  localparam byte_t TERM   = 8'h00;

  logic clk = 1'b0;
  logic reset;
  logic restart;
  logic core_reset;
  logic loaded;
  logic error;

  int checks = 0;
  int fails  = 0;

  byte_t irom [IDEPTH];
  byte_t ops  [8];

  bf_boot_sequencer_if #(
    .IA_WIDTH(IAW), .ID_WIDTH(8),
    .DA_WIDTH(DAW), .DD_WIDTH(8)
  ) bus ();

  bf_boot_sequencer #(
    .IA_WIDTH(IAW), .ID_WIDTH(8),
    .DA_WIDTH(DAW), .DD_WIDTH(8),
    .TERMINATOR(TERM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .bus        (bus),
    .core_reset (core_reset),
    .loaded     (loaded),
    .error      (error)
  );

  always #5 clk = ~clk;

  // IROM image as the core would see it, plus per-cycle pulse rules
  always @(negedge clk) begin
    if (bus.iwce === 1'b1) irom[bus.iwa] = bus.iwd;
    checks++;
    if (bus.iwce !== bus.rxack || (bus.dwce && bus.iwce)
        || bus.dwq !== 8'h00) begin
      fails++;
      $display("FAIL pulse_rules: iwce=%b rxack=%b dwce=%b dwq=%h, required iwce==rxack, not dwce&iwce, dwq=00",
               bus.iwce, bus.rxack, bus.dwce, bus.dwq);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(output int n, output bit seq_ok,
                            output bit quiet);
    int guard;
    guard  = 0;
    n      = 0;
    seq_ok = 1'b1;
    quiet  = 1'b1;
    while (bus.dwce !== 1'b1 && guard < 4) begin
      tick();
      guard++;
    end
    while (bus.dwce === 1'b1 && n < 40) begin
      if (bus.dwa !== DAW'(n)) seq_ok = 1'b0;
      if (bus.rxack !== 1'b0 || core_reset !== 1'b1) quiet = 1'b0;
      n++;
      tick();
    end
  endtask

  task automatic run_program(input byte_t prog[$], input int gap);
    int    t;
    int    nacc;
    int    g;
    bit    ack;
    bit    ok;
    logic [2:0] exp_st;
    t = -1;
    foreach (prog[i]) if (t < 0 && prog[i] == TERM) t = i;
    ok     = (t >= 0 && t < IDEPTH);
    nacc   = ok ? t + 1 : IDEPTH;
    exp_st = ok ? 3'b010 : 3'b101;
    for (int i = 0; i < IDEPTH; i++) irom[i] = 'x;
    for (int i = 0; i < prog.size(); i++) begin
      ack = (i < nacc);
      g = (gap < 0) ? int'($urandom_range(2)) : gap;
      repeat (g) tick();
      bus.rxd   = prog[i];
      bus.rxrda = 1'b1;
      tick();
      checks++;
      if (ack) begin
        if (bus.rxack !== 1'b1 || bus.iwa !== IAW'(i)
            || bus.iwd !== prog[i] || core_reset !== 1'b1) begin
          fails++;
          $display("FAIL byte_ack[%0d]: rxack=%b iwa=%0d iwd=%h core_reset=%b, required 1 %0d %h 1",
                   i, bus.rxack, bus.iwa, bus.iwd, core_reset,
                   i, prog[i]);
        end
      end else if (bus.rxack !== 1'b0) begin
        fails++;
        $display("FAIL byte_ignored[%0d]: rxack=%b, required 0",
                 i, bus.rxack);
      end
      bus.rxrda = 1'b0;
      tick();
      if (i == nacc - 1 || !ack) begin
        checks++;
        if ({core_reset, loaded, error} !== exp_st) begin
          fails++;
          $display("FAIL outcome[%0d]: core_reset,loaded,error=%b, required %b",
                   i, {core_reset, loaded, error}, exp_st);
        end
      end
    end
    for (int i = 0; i < nacc && i < prog.size(); i++) begin
      checks++;
      if (irom[i] !== prog[i]) begin
        fails++;
        $display("FAIL irom[%0d]: got %h, required %h",
                 i, irom[i], prog[i]);
      end
    end
  endtask

  task automatic test_reset();
    bus.rxd   = 8'h00;
    bus.rxrda = 1'b0;
    restart   = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    checks++;
    if ({core_reset, loaded, error, bus.dwce, bus.iwce, bus.rxack}
        !== 6'b100000) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 100000",
               {core_reset, loaded, error, bus.dwce, bus.iwce,
                bus.rxack});
    end
    checks++;
    if (bus.dwa !== '0 || bus.iwa !== '0) begin
      fails++;
      $display("FAIL reset_addr: dwa=%0d iwa=%0d, required 0 0",
               bus.dwa, bus.iwa);
    end
  endtask

  task automatic test_clear(input bit hold_rx);
    int n;
    bit seq_ok;
    bit quiet;
    bus.rxrda = hold_rx;
    bus.rxd   = 8'h2B;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear(n, seq_ok, quiet);
    checks++;
    if (n != DDEPTH || !seq_ok || !quiet) begin
      fails++;
      $display("FAIL clear: cycles=%0d seq=%b quiet=%b, required %0d 1 1",
               n, seq_ok, quiet, DDEPTH);
    end
    if (hold_rx) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (bus.rxack !== 1'(c % 2)) begin
          fails++;
          $display("FAIL held_rx_ack[%0d]: rxack=%b, required %0d",
                   c, bus.rxack, c % 2);
        end
        tick();
      end
    end
    bus.rxrda = 1'b0;
  endtask

  task automatic restart_clear(input string tag);
    int n;
    bit seq_ok;
    bit quiet;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({bus.dwce, loaded, error} !== 3'b100 || bus.dwa !== '0) begin
      fails++;
      $display("FAIL %s_restart: dwce,loaded,error=%b dwa=%0d, required 100 0",
               tag, {bus.dwce, loaded, error}, bus.dwa);
    end
    wait_clear(n, seq_ok, quiet);
    checks++;
    if (n != DDEPTH || !seq_ok || !quiet) begin
      fails++;
      $display("FAIL %s_clear: cycles=%0d seq=%b quiet=%b, required %0d 1 1",
               tag, n, seq_ok, quiet, DDEPTH);
    end
  endtask

  task automatic test_program();
    byte_t p[$];
    restart_clear("prog");
    p.push_back(8'h2B);
    p.push_back(8'h2E);
    p.push_back(8'h00);
    p.push_back(8'h2B);
    run_program(p, 1);
  endtask

  task automatic test_overflow();
    byte_t p[$];
    restart_clear("ovf");
    for (int i = 0; i < IDEPTH + 1; i++) p.push_back(8'h2B);
    run_program(p, 0);
  endtask

  task automatic test_restart();
    byte_t p[$];
    int n;
    bit seq_ok;
    bit quiet;
    restart_clear("rst");
    repeat ($urandom_range(10, 3)) tick();
    restart_clear("rst_midclear");
    p.push_back(8'h2B);
    p.push_back(8'h3E);
    run_program(p, 0);
    bus.rxd   = 8'h2D;
    bus.rxrda = 1'b1;
    restart   = 1'b1;
    tick();
    restart   = 1'b0;
    bus.rxrda = 1'b0;
    checks++;
    if (bus.rxack !== 1'b0 || bus.dwce !== 1'b1 || bus.dwa !== '0) begin
      fails++;
      $display("FAIL restart_beats_byte: rxack=%b dwce=%b dwa=%0d, required 0 1 0",
               bus.rxack, bus.dwce, bus.dwa);
    end
    wait_clear(n, seq_ok, quiet);
    checks++;
    if (n != DDEPTH || !seq_ok || {loaded, error} !== 2'b00) begin
      fails++;
      $display("FAIL restart_reclear: cycles=%0d seq=%b loaded,error=%b, required %0d 1 00",
               n, seq_ok, {loaded, error}, DDEPTH);
    end
    p.delete();
    p.push_back(8'h5B);
    p.push_back(8'h00);
    run_program(p, 0);
  endtask

  task automatic test_random();
    byte_t p[$];
    for (int it = 0; it < 6; it++) begin
      restart_clear("rand");
      p.delete();
      for (int i = 0; i < IDEPTH + 2; i++) begin
        if ($urandom_range(7) == 0) p.push_back(TERM);
        else p.push_back(ops[$urandom_range(7)]);
      end
      run_program(p, -1);
    end
  endtask

  task automatic test_back_to_back();
    byte_t p[$];
    restart_clear("b2b");
    for (int i = 0; i < 9; i++) p.push_back(ops[i % 8]);
    p.push_back(TERM);
    run_program(p, 0);
  endtask

  task automatic test_reset_restart_run();
    byte_t p[$];
    int n;
    bit seq_ok;
    bit quiet;
    restart_clear("rr");
    p.push_back(8'h2C);
    p.push_back(8'h00);
    run_program(p, 0);
    reset   = 1'b1;
    restart = 1'b1;
    tick();
    reset   = 1'b0;
    restart = 1'b0;
    checks++;
    if ({core_reset, loaded, error, bus.dwce, bus.iwce, bus.rxack}
        !== 6'b100000 || bus.dwa !== '0 || bus.iwa !== '0) begin
      fails++;
      $display("FAIL reset_in_run: flags=%b dwa=%0d iwa=%0d, required 100000 0 0",
               {core_reset, loaded, error, bus.dwce, bus.iwce,
                bus.rxack}, bus.dwa, bus.iwa);
    end
    wait_clear(n, seq_ok, quiet);
    checks++;
    if (n != DDEPTH || !seq_ok || !quiet) begin
      fails++;
      $display("FAIL reset_in_run_clear: cycles=%0d seq=%b quiet=%b, required %0d 1 1",
               n, seq_ok, quiet, DDEPTH);
    end
  endtask

  initial begin
    ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h3C; ops[3] = 8'h3E;
    ops[4] = 8'h2E; ops[5] = 8'h2C; ops[6] = 8'h5B; ops[7] = 8'h5D;
    test_reset();
    test_clear(1'b0);
    test_clear(1'b1);
    test_program();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_random();
    test_reset_restart_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
